// File: rtl/i4004_bus_master.sv
// i4004_bus_master
//   CPU-side initiator of the 4-bit multiplexed i4001 ROM bus. Sequences the
//   eight-phase instruction cycle A1 A2 A3 M1 M2 X1 X2 X3, drives the 12-bit
//   program counter out as three nibbles, and captures the 8-bit opcode the
//   ROM returns in M1/M2.
//
//   Optional feature: define I4004_BUS_HALT_EN to add the `halt` input, which
//   holds the block in X3 (sync high, PC frozen) for as long as it is asserted.
//
// Parameters
//   RESET_PC      PC value after reset
//   STEP_DIV      enabled CLKs per phase (>=1)
//
// Ports
//   CLK           in   system clock
//   RESET         in   asynchronous, active-high reset
//   run           in   keep issuing instruction cycles
//   phase_en      in   phase-advance qualifier
//   jump_load     in   load jump_addr into PC at X3 exit
//   jump_addr     in   [11:0] jump target
//   data_in       in   [3:0] bus value read from ROM
//   halt          in   (I4004_BUS_HALT_EN only) hold in X3
//   data_out      out  [3:0] bus value driven to ROM
//   data_oe       out  data_out drives the bus (A1..A3)
//   sync          out  high during X3
//   cm_rom        out  high during A3
//   phase         out  [2:0] 0=A1 .. 7=X3, 0 while idle
//   busy          out  not idle
//   pc            out  [11:0] current fetch address
//   opcode        out  [7:0] last fetched opcode
//   opcode_valid  out  one-CLK pulse when opcode is updated
module i4004_bus_master #(
   parameter logic [11:0] RESET_PC = 12'h000,
   parameter int unsigned STEP_DIV = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        run,
   input  logic        phase_en,
   input  logic        jump_load,
   input  logic [11:0] jump_addr,
   input  logic [3:0]  data_in,
`ifdef I4004_BUS_HALT_EN
   input  logic        halt,
`endif
   output logic [3:0]  data_out,
   output logic        data_oe,
   output logic        sync,
   output logic        cm_rom,
   output logic [2:0]  phase,
   output logic        busy,
   output logic [11:0] pc,
   output logic [7:0]  opcode,
   output logic        opcode_valid
);

   localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   // Active phases are encoded 0..7 so the low bits are the phase number;
   // bit 3 marks idle.
   localparam logic [3:0] ST_A1   = 4'd0;
   localparam logic [3:0] ST_A2   = 4'd1;
   localparam logic [3:0] ST_A3   = 4'd2;
   localparam logic [3:0] ST_M1   = 4'd3;
   localparam logic [3:0] ST_M2   = 4'd4;
   localparam logic [3:0] ST_X1   = 4'd5;
   localparam logic [3:0] ST_X2   = 4'd6;
   localparam logic [3:0] ST_X3   = 4'd7;
   localparam logic [3:0] ST_IDLE = 4'd8;

   logic [3:0]       state_q, state_d;
   logic [11:0]      pc_q, pc_d;
   logic [7:0]       opcode_q, opcode_d;
   logic             valid_q, valid_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             step;
   logic             halt_w;

`ifdef I4004_BUS_HALT_EN
   assign halt_w = halt;
`else
   assign halt_w = 1'b0;
`endif

   assign step = phase_en && (div_q == DIV_W'(STEP_DIV - 1));

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opcode_d = opcode_q;
      valid_d  = 1'b0;
      div_d    = div_q;
      if (phase_en) begin
         div_d = step ? '0 : div_q + DIV_W'(1);
      end
      if (step) begin
         case (state_q)
            ST_IDLE: if (run) state_d = ST_A1;
            ST_M1: begin
               opcode_d[7:4] = data_in;
               state_d       = ST_M2;
            end
            ST_M2: begin
               opcode_d[3:0] = data_in;
               valid_d       = 1'b1;
               state_d       = ST_X1;
            end
            ST_X3: begin
               // A halted X3 exit is simply not taken; div still clears.
               if (!halt_w) begin
                  pc_d    = jump_load ? jump_addr : pc_q + 12'd1;
                  state_d = run ? ST_A1 : ST_IDLE;
               end
            end
            default: state_d = state_q + 4'd1;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         opcode_q <= '0;
         valid_q  <= 1'b0;
         div_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         valid_q  <= valid_d;
         div_q    <= div_d;
      end
   end

   // Bus outputs decode registered state only, so they are stable for the
   // whole phase and drop immediately on reset.
   always_comb begin
      data_out = '0;
      data_oe  = 1'b0;
      case (state_q)
         ST_A1: begin data_out = pc_q[3:0];  data_oe = 1'b1; end
         ST_A2: begin data_out = pc_q[7:4];  data_oe = 1'b1; end
         ST_A3: begin data_out = pc_q[11:8]; data_oe = 1'b1; end
         default: ;
      endcase
   end

   assign sync         = (state_q == ST_X3);
   assign cm_rom       = (state_q == ST_A3);
   assign busy         = !state_q[3];
   assign phase        = state_q[3] ? 3'd0 : state_q[2:0];
   assign pc           = pc_q;
   assign opcode       = opcode_q;
   assign opcode_valid = valid_q;

endmodule

// File: tb/tb_i4004_bus_master.sv
module tb_i4004_bus_master;

   logic        CLK = 1'b0;
   logic        RESET, run, pe1, pe3, jump_load;
   logic [11:0] jump_addr;
   logic [3:0]  data_in;
`ifdef I4004_BUS_HALT_EN
   logic        halt;
`endif

   logic [3:0]  d1_dout, d3_dout;
   logic        d1_oe, d1_sync, d1_cm, d1_busy, d1_ov;
   logic        d3_oe, d3_sync, d3_cm, d3_busy, d3_ov;
   logic [2:0]  d1_phase, d3_phase;
   logic [11:0] d1_pc, d3_pc;
   logic [7:0]  d1_op, d3_op;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 CLK = ~CLK;

   i4004_bus_master #(.RESET_PC(12'h000), .STEP_DIV(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .run(run), .phase_en(pe1),
      .jump_load(jump_load), .jump_addr(jump_addr), .data_in(data_in),
`ifdef I4004_BUS_HALT_EN
      .halt(halt),
`endif
      .data_out(d1_dout), .data_oe(d1_oe), .sync(d1_sync), .cm_rom(d1_cm),
      .phase(d1_phase), .busy(d1_busy), .pc(d1_pc), .opcode(d1_op),
      .opcode_valid(d1_ov)
   );

   i4004_bus_master #(.RESET_PC(12'h3C5), .STEP_DIV(3)) dut3 (
      .CLK(CLK), .RESET(RESET), .run(run), .phase_en(pe3),
      .jump_load(jump_load), .jump_addr(jump_addr), .data_in(data_in),
`ifdef I4004_BUS_HALT_EN
      .halt(1'b0),
`endif
      .data_out(d3_dout), .data_oe(d3_oe), .sync(d3_sync), .cm_rom(d3_cm),
      .phase(d3_phase), .busy(d3_busy), .pc(d3_pc), .opcode(d3_op),
      .opcode_valid(d3_ov)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   // phase / busy / data_oe / data_out / cm_rom / sync of dut1
   task automatic chk1(input string tag, input logic [2:0] ph, input logic bz,
                       input logic oe, input logic [3:0] dout, input logic cm,
                       input logic sy);
      chk({tag, ".phase"}, 32'(d1_phase), 32'(ph));
      chk({tag, ".busy"},  32'(d1_busy),  32'(bz));
      chk({tag, ".oe"},    32'(d1_oe),    32'(oe));
      chk({tag, ".dout"},  32'(d1_dout),  32'(dout));
      chk({tag, ".cm"},    32'(d1_cm),    32'(cm));
      chk({tag, ".sync"},  32'(d1_sync),  32'(sy));
   endtask

   initial begin
      int unsigned steps;
      logic [3:0] exp_dout;
      RESET = 1'b1; run = 1'b0; pe1 = 1'b1; pe3 = 1'b0;
      jump_load = 1'b0; jump_addr = 12'h000; data_in = 4'h0;
`ifdef I4004_BUS_HALT_EN
      halt = 1'b0;
`endif
      ticks(2);
      chk1("rst", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("rst.pc",  32'(d1_pc), 32'h000);
      chk("rst.op",  32'(d1_op), 32'h00);
      chk("rst.ov",  32'(d1_ov), 32'h0);
      chk("rst.pc3", 32'(d3_pc), 32'h3C5);
      RESET = 1'b0;

      // basic fetch of opcode D4 at pc 0
      run = 1'b1;
      tick(); chk1("c1.A1", 3'd0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      tick(); chk1("c1.A2", 3'd1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      tick(); chk1("c1.A3", 3'd2, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
      tick(); chk1("c1.M1", 3'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      data_in = 4'hD;
      tick(); chk1("c1.M2", 3'd4, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("c1.M2.ov", 32'(d1_ov), 32'h0);
      data_in = 4'h4;
      tick(); chk("c1.X1.op", 32'(d1_op), 32'hD4);
      chk("c1.X1.ov", 32'(d1_ov), 32'h1);
      tick(); chk("c1.X2.ov", 32'(d1_ov), 32'h0);
      chk1("c1.X2", 3'd6, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      tick(); chk1("c1.X3", 3'd7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      chk("c1.X3.pc", 32'(d1_pc), 32'h000);
      tick(); chk("c2.A1.pc", 32'(d1_pc), 32'h001);
      chk1("c2.A1", 3'd0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);

      // jump_load in A2 only is ignored
      tick(); jump_load = 1'b1; jump_addr = 12'hFFF;
      tick(); jump_load = 1'b0;
      ticks(5); chk("c2.X3.sync", 32'(d1_sync), 32'h1);
      tick(); chk("c3.A1.pc", 32'(d1_pc), 32'h002);

      // jump to FFF, then wrap to 000
      ticks(7); jump_load = 1'b1; jump_addr = 12'hFFF;
      tick(); jump_load = 1'b0;
      chk("c4.A1.pc", 32'(d1_pc), 32'hFFF);
      chk1("c4.A1", 3'd0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
      tick(); chk("c4.A2.dout", 32'(d1_dout), 32'hF);
      tick(); chk("c4.A3.dout", 32'(d1_dout), 32'hF);
      ticks(5);
      tick(); chk("c5.A1.pc", 32'(d1_pc), 32'h000);
      chk1("c5.A1", 3'd0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
      tick(); chk("c5.A2.dout", 32'(d1_dout), 32'h0);
      tick(); chk("c5.A3.dout", 32'(d1_dout), 32'h0);

      // run dropped in M1, jump held through X3 exit
      tick(); run = 1'b0; jump_load = 1'b1; jump_addr = 12'h5A3;
      ticks(4); chk1("c5.X3", 3'd7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      chk("c5.X3.pc", 32'(d1_pc), 32'h000);
      tick(); jump_load = 1'b0;
      chk("idle.pc", 32'(d1_pc), 32'h5A3);
      chk1("idle", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      tick(); chk("idle2.busy", 32'(d1_busy), 32'h0);

      // restart, reset in the middle of A2
      run = 1'b1;
      tick(); chk("c6.A1.dout", 32'(d1_dout), 32'h3);
      tick(); chk("c6.A2.dout", 32'(d1_dout), 32'hA);
      chk("c6.A2.oe", 32'(d1_oe), 32'h1);
      chk("c6.A2.op", 32'(d1_op), 32'h44);
      RESET = 1'b1; #1;
      chk1("mrst", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("mrst.pc", 32'(d1_pc), 32'h000);
      chk("mrst.op", 32'(d1_op), 32'h00);
      pe1 = 1'b0;
      tick(); RESET = 1'b0;

      // STEP_DIV=3 with phase_en toggling
      for (int unsigned h = 1; h <= 9; h++) begin
         steps = h / 3;
         case (steps)
            1: exp_dout = 4'h5;
            2: exp_dout = 4'hC;
            3: exp_dout = 4'h3;
            default: exp_dout = 4'h0;
         endcase
         for (int unsigned lo = 0; lo < 2; lo++) begin
            pe3 = (lo == 0);
            tick();
            chk("div.busy",  32'(d3_busy),  32'(steps > 0));
            chk("div.phase", 32'(d3_phase), (steps > 0) ? steps - 1 : 0);
            chk("div.dout",  32'(d3_dout),  32'(exp_dout));
            chk("div.oe",    32'(d3_oe),    32'(steps > 0));
         end
      end
      chk("div.cm",     32'(d3_cm),   32'h1);
      chk("hold1.busy", 32'(d1_busy), 32'h0);

`ifdef I4004_BUS_HALT_EN
      pe1 = 1'b1;
      ticks(8); chk("halt.X3", 32'(d1_sync), 32'h1);
      halt = 1'b1;
      for (int unsigned s = 0; s < 5; s++) begin
         tick();
         chk("halt.sync",  32'(d1_sync),  32'h1);
         chk("halt.phase", 32'(d1_phase), 32'h7);
         chk("halt.pc",    32'(d1_pc),    32'h000);
      end
      halt = 1'b0;
      tick(); chk("halt.rel.pc", 32'(d1_pc), 32'h001);
      chk1("halt.rel", 3'd0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
